// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one shift-add multiplier core among NREQ clients.
// Optional WAIT watchdog is compiled in with `define MULT_TIMEOUT_EN.
module mult_arbiter #(
    parameter int NREQ   = 4,
    parameter int W      = 4,
    parameter int TO_CYC = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [2*W-1:0]    rsp_data,
    output logic              busy,
    output logic              m_init,
    output logic [W-1:0]      m_a,
    output logic [W-1:0]      m_b,
    input  logic [2*W-1:0]    m_pp,
    input  logic              m_done,
    output logic              err
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win_r;
    logic [PW-1:0] win;
    logic          found;

    // Search starts just after the last winner so every client gets a turn.
    always_comb begin
        int idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

`ifdef MULT_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC + 1);
    logic [CW-1:0] to_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= PW'(NREQ - 1);
            win_r     <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            m_init    <= 1'b0;
            m_a       <= '0;
            m_b       <= '0;
`ifdef MULT_TIMEOUT_EN
            to_cnt    <= '0;
            err       <= 1'b0;
`endif
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
`ifdef MULT_TIMEOUT_EN
            err       <= 1'b0;
`endif
            case (state)
                IDLE: if (found) begin
                    gnt    <= NREQ'(1) << win;
                    m_a    <= a_in[win*W +: W];
                    m_b    <= b_in[win*W +: W];
                    win_r  <= win;
                    m_init <= 1'b1;
                    busy   <= 1'b1;
                    state  <= START;
                end
                // Hold init until the core drops a stale done from the last operation.
                START: if (!m_done) begin
                    m_init <= 1'b0;
                    state  <= WAIT;
`ifdef MULT_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (m_done) begin
                        rsp_data  <= m_pp;
                        rsp_valid <= NREQ'(1) << win_r;
                        state     <= RESP;
                    end
`ifdef MULT_TIMEOUT_EN
                    else if (to_cnt == CW'(TO_CYC - 1)) begin
                        rsp_data  <= '0;
                        rsp_valid <= NREQ'(1) << win_r;
                        err       <= 1'b1;
                        state     <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    ptr   <= win_r;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed table-driven bench for mult_arbiter with a behavioural multi-cycle multiplier core.
module tb_mult_arbiter;

    localparam int NREQ = 4, W = 4, TO_CYC = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] a_in, b_in;
    logic [3:0]  gnt, rsp_valid;
    logic [7:0]  rsp_data, m_pp;
    logic        busy, m_init, m_done, err;
    logic [3:0]  m_a, m_b;

    int tests = 0, fails = 0;
    int lat = 3;
    bit force_off = 1'b0;
    int mcnt;

    mult_arbiter #(.NREQ(NREQ), .W(W), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .m_init(m_init), .m_a(m_a), .m_b(m_b), .m_pp(m_pp), .m_done(m_done),
        .err(err)
    );

    always #5 clk = ~clk;

    // Core model: init clears done, then lat cycles later done rises (level) with A*B.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_done <= 1'b0;
            m_pp   <= '0;
            mcnt   <= 0;
        end else if (m_init) begin
            m_done <= 1'b0;
            mcnt   <= lat;
        end else if (!m_done && !force_off) begin
            if (mcnt > 0) mcnt <= mcnt - 1;
            else begin
                m_done <= 1'b1;
                m_pp   <= 8'(m_a) * 8'(m_b);
            end
        end
    end

    typedef struct {
        logic [3:0]       req;
        logic [3:0]       sticky;
        logic [15:0]      a;
        logic [15:0]      b;
        logic             rf;
        int               n;
        logic [3:0][1:0]  cl;
        logic [3:0][7:0]  prod;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1; req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        int nr, ng, ni, cyc, w;
        logic prev_init;
        v = vecs[k]; nr = 0; ng = 0; ni = 0; cyc = 0;
        if (v.rf) do_reset();
        a_in = v.a; b_in = v.b; req = v.req;
        prev_init = m_init;
        while (cyc < 400) begin
            @(negedge clk); cyc++;
            if (gnt != 0) begin
                w = idx_of(gnt);
                chk($sformatf("v%0d_gnt_onehot", k), 32'($onehot(gnt)), 32'd1);
                chk($sformatf("v%0d_m_a", k), 32'(m_a), 32'(v.a[w*4 +: 4]));
                chk($sformatf("v%0d_m_b", k), 32'(m_b), 32'(v.b[w*4 +: 4]));
                ng++;
                if (!v.sticky[w]) req[w] = 1'b0;
            end
            if (m_init && !prev_init) ni++;
            prev_init = m_init;
            if (rsp_valid != 0) begin
                w = idx_of(rsp_valid);
                chk($sformatf("v%0d_rsp_onehot", k), 32'($onehot(rsp_valid)), 32'd1);
                if (nr < v.n) begin
                    chk($sformatf("v%0d_rsp%0d_client", k, nr), 32'(w), 32'(v.cl[nr]));
                    chk($sformatf("v%0d_rsp%0d_data", k, nr), 32'(rsp_data), 32'(v.prod[nr]));
                    chk($sformatf("v%0d_rsp%0d_busy", k, nr), 32'(busy), 32'd1);
                    chk($sformatf("v%0d_rsp%0d_err", k, nr), 32'(err), 32'd0);
                end
                nr++;
                if (nr >= v.n) req = '0;
            end
            if (nr >= v.n && !busy) break;
        end
        chk($sformatf("v%0d_rsp_count", k), 32'(nr), 32'(v.n));
        chk($sformatf("v%0d_gnt_count", k), 32'(ng), 32'(v.n));
        chk($sformatf("v%0d_init_count", k), 32'(ni), 32'(v.n));
    endtask

    initial begin
        int gc, rc, cyc;
        rst = 1'b0; req = '0; a_in = '0; b_in = '0;

        vecs[0] = '{req:4'b0001, sticky:4'b0000, a:16'h0003, b:16'h0005, rf:1'b1, n:1,
                    cl:{2'd0, 2'd0, 2'd0, 2'd0}, prod:{8'd0, 8'd0, 8'd0, 8'd15}};
        vecs[1] = '{req:4'b1111, sticky:4'b0000, a:16'h4321, b:16'h2222, rf:1'b1, n:4,
                    cl:{2'd3, 2'd2, 2'd1, 2'd0}, prod:{8'd8, 8'd6, 8'd4, 8'd2}};
        vecs[2] = '{req:4'b0101, sticky:4'b0101, a:16'h0402, b:16'h0503, rf:1'b1, n:4,
                    cl:{2'd2, 2'd0, 2'd2, 2'd0}, prod:{8'd20, 8'd6, 8'd20, 8'd6}};
        vecs[3] = '{req:4'b0001, sticky:4'b0000, a:16'h000F, b:16'h000F, rf:1'b1, n:1,
                    cl:{2'd0, 2'd0, 2'd0, 2'd0}, prod:{8'd0, 8'd0, 8'd0, 8'd225}};
        vecs[4] = '{req:4'b0100, sticky:4'b0000, a:16'h0000, b:16'h0900, rf:1'b1, n:1,
                    cl:{2'd0, 2'd0, 2'd0, 2'd2}, prod:{8'd0, 8'd0, 8'd0, 8'd0}};
        // Run without reset after the 1,3 pair: pointer sits at 3, so 0 wins before 3.
        vecs[5] = '{req:4'b1001, sticky:4'b0000, a:16'hD001, b:16'h2006, rf:1'b0, n:2,
                    cl:{2'd0, 2'd0, 2'd3, 2'd0}, prod:{8'd0, 8'd0, 8'd26, 8'd6}};
        vecs[6] = '{req:4'b0010, sticky:4'b0000, a:16'h0050, b:16'h0060, rf:1'b0, n:1,
                    cl:{2'd0, 2'd0, 2'd0, 2'd1}, prod:{8'd0, 8'd0, 8'd0, 8'd30}};

        do_reset();
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_m_init", 32'(m_init), 32'd0);
        chk("rst_m_ab", 32'({m_a, m_b}), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        for (int k = 0; k < 5; k++) run_vec(k);

        // Pair 1,3 from reset, then the no-reset wrap vector.
        do_reset();
        a_in = 16'hC070; b_in = 16'hB090; req = 4'b1010;
        gc = 0; rc = 0; cyc = 0;
        while (cyc < 200 && rc < 2) begin
            @(negedge clk); cyc++;
            if (gnt != 0) req = req & ~gnt;
            if (rsp_valid != 0) begin
                chk($sformatf("pair_rsp%0d_client", rc), 32'(idx_of(rsp_valid)), (rc == 0) ? 32'd1 : 32'd3);
                chk($sformatf("pair_rsp%0d_data", rc), 32'(rsp_data), (rc == 0) ? 32'd63 : 32'd132);
                rc++;
            end
        end
        chk("pair_rsp_count", 32'(rc), 32'd2);
        @(negedge clk);
        chk("pair_idle_busy", 32'(busy), 32'd0);
        run_vec(5);

        // Reset while the core is still computing: the operation is dropped.
        do_reset();
        lat = 10;
        a_in = 16'h0009; b_in = 16'h0009; req = 4'b0001;
        cyc = 0;
        while (cyc < 20 && gnt == 0) begin @(negedge clk); cyc++; end
        chk("midrst_gnt_seen", 32'(gnt), 32'd1);
        req = '0;
        repeat (4) @(negedge clk);
        chk("midrst_in_wait", 32'({m_init, busy}), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rc = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid != 0 || busy) rc++;
        end
        chk("midrst_quiet", 32'(rc), 32'd0);
        lat = 3;
        run_vec(6);

`ifdef MULT_TIMEOUT_EN
        do_reset();
        force_off = 1'b1;
        a_in = 16'h0003; b_in = 16'h0003; req = 4'b0001;
        gc = -1; rc = -1; cyc = 0;
        while (cyc < 100 && rc < 0) begin
            @(negedge clk); cyc++;
            if (gnt != 0) begin gc = cyc; req = '0; end
            if (rsp_valid != 0) begin
                rc = cyc;
                chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("to_rsp_data", 32'(rsp_data), 32'd0);
                chk("to_err", 32'(err), 32'd1);
            end
        end
        chk("to_latency", 32'(rc - gc), 32'(TO_CYC + 1));
        @(negedge clk);
        chk("to_err_pulse", 32'(err), 32'd0);
        force_off = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
